pole_serial: RTL and testbench

Recursive (pole) section of the IIR datapath; consumes the 21-bit output of the parallel symmetric zero section and closes the feedback loop.
Computes y[n] = floor((x[n] - sum_{k=1..ORDER} a_k*y[n-k]) / 2^SHIFT) with a single time-multiplexed multiplier, one tap per clock.
Valid/ready input handshake, single-cycle output strobe, runtime-writable feedback coefficients.

---
 rtl/pole_serial.sv | 147 ++++++++++++++
 tb/tb_pole_serial.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pole_serial.sv
// pole_serial -- recursive (pole) section of the IIR datapath.
//
// This block computes the following, where x is already scaled by 2^SHIFT
// by the zero section:
//   y[n] = floor((x[n] - sum_{k=1..ORDER} a_k*y[n-k]) / 2^SHIFT)
// A single multiplier is time-multiplexed and evaluates one tap per clock.
// A new sample can be taken every ORDER+2 cycles. dout_valid is high in the
// cycle after the (ORDER+1)th edge that follows the accept.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   din/din_valid     signed input sample x[n], with a valid/ready handshake
//   din_ready         high only when the block is idle
//   dout/dout_valid   signed y[n], qualified by a one-cycle strobe; dout
//                     holds its value between strobes
//   coe_we/addr/data  write of a_k (k = 1..ORDER); honoured only when idle
//   hist_clr          clears the feedback history; aborts a sample in flight
//   ovf               sticky saturation flag
//
// Build option: when POLE_SAT_EN is defined, an out-of-range y clamps to the
// DOUT_W bounds and ovf becomes sticky. When it is not defined, y wraps to
// DOUT_W bits and ovf is tied to 0.
module pole_serial #(
    parameter int DIN_W  = 21,
    parameter int DOUT_W = 12,
    parameter int COE_W  = 12,
    parameter int ORDER  = 7,
    parameter int SHIFT  = 9,
    parameter int ACC_W  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_valid,
    input  logic              coe_we,
    input  logic [2:0]        coe_addr,
    input  logic [COE_W-1:0]  coe_data,
    input  logic              hist_clr,
    output logic              ovf
);
    localparam int K_W = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam int P_W = COE_W + DOUT_W;
    localparam logic [K_W-1:0] LAST_TAP = K_W'(ORDER - 1);
    localparam logic [2:0]     MAX_ADDR = 3'(ORDER);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    // The tap counter is 0-based: tap t applies a_{t+1} to y[n-1-t].
    logic [K_W-1:0]           tap;
    logic signed [COE_W-1:0]  coe  [ORDER];
    logic signed [DOUT_W-1:0] hist [ORDER];
    logic signed [P_W-1:0]    prod;
    logic signed [DOUT_W-1:0] y_res;
    logic                     coe_hit;

    assign prod    = P_W'(coe[tap]) * P_W'(hist[tap]);
    assign coe_hit = coe_we && (state == IDLE) &&
                     (coe_addr != 3'd0) && (coe_addr <= MAX_ADDR);

`ifdef POLE_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2**(DOUT_W-1) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    logic signed [ACC_W-1:0] y_full;
    logic                    y_sat;

    always_comb begin
        y_full = acc >>> SHIFT;
        y_sat  = 1'b1;
        if (y_full > Y_MAX)      y_res = Y_MAX[DOUT_W-1:0];
        else if (y_full < Y_MIN) y_res = Y_MIN[DOUT_W-1:0];
        else begin
            y_res = y_full[DOUT_W-1:0];
            y_sat = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == OUT && !hist_clr && y_sat)
            ovf <= 1'b1;
    end
`else
    // An arithmetic shift followed by truncation reduces to a plain bit slice.
    assign y_res = acc[SHIFT +: DOUT_W];
    assign ovf   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            tap        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
            for (int i = 0; i < ORDER; i++) begin
                coe[i]  <= '0;
                hist[i] <= '0;
            end
        end else begin
            dout_valid <= 1'b0;
            // A write made in the accept cycle lands before the first MAC
            // edge, so that sample already uses the new coefficient.
            if (coe_hit)
                coe[K_W'(coe_addr - 3'd1)] <= coe_data;

            if (hist_clr) begin
                // Wipes the history and drops any sample in flight; this
                // takes priority over an accept.
                for (int i = 0; i < ORDER; i++) hist[i] <= '0;
                state     <= IDLE;
                tap       <= '0;
                din_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (din_valid && din_ready) begin
                        acc       <= {{(ACC_W-DIN_W){din[DIN_W-1]}}, din};
                        tap       <= '0;
                        din_ready <= 1'b0;
                        state     <= MAC;
                    end
                    MAC: begin
                        acc <= acc - {{(ACC_W-P_W){prod[P_W-1]}}, prod};
                        tap <= tap + K_W'(1);
                        if (tap == LAST_TAP) state <= OUT;
                    end
                    OUT: begin
                        dout       <= y_res;
                        dout_valid <= 1'b1;
                        for (int i = ORDER-1; i > 0; i--) hist[i] <= hist[i-1];
                        hist[0]    <= y_res;
                        din_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pole_serial.sv
// Testbench for pole_serial.
// The stimulus is a mix of directed and random steps. Every expected output
// comes either from a constant or from a reference model that evaluates the
// difference equation with integer arithmetic.
module tb_pole_serial;
    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [11:0] dout;
    logic        dout_valid;
    logic        coe_we;
    logic [2:0]  coe_addr;
    logic [11:0] coe_data;
    logic        hist_clr;
    logic        ovf;

    pole_serial dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .coe_we(coe_we), .coe_addr(coe_addr), .coe_data(coe_data),
        .hist_clr(hist_clr), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: coefficients a_1..a_7 and history y[n-1..n-7].
    int m_coef [1:7];
    int m_hist [1:7];
    bit m_ovf;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 1; k <= 7; k++) begin m_coef[k] = 0; m_hist[k] = 0; end
        m_ovf = 1'b0;
    endfunction

    function automatic void model_clr();
        for (int k = 1; k <= 7; k++) m_hist[k] = 0;
    endfunction

    function automatic int model_step(input int x);
        longint a, q;
        a = x;
        for (int k = 1; k <= 7; k++) a -= longint'(m_coef[k]) * m_hist[k];
        q = a / 512;
        if ((a % 512) != 0 && a < 0) q = q - 1;      // floor toward -inf
`ifdef POLE_SAT_EN
        if (q > 2047)       begin q = 2047;  m_ovf = 1'b1; end
        else if (q < -2048) begin q = -2048; m_ovf = 1'b1; end
`else
        q = ((q % 4096) + 4096) % 4096;
        if (q >= 2048) q = q - 4096;
`endif
        for (int k = 7; k > 1; k--) m_hist[k] = m_hist[k-1];
        m_hist[1] = int'(q);
        return int'(q);
    endfunction

    task automatic write_coe(input int k, input int v);
        coe_we = 1'b1; coe_addr = 3'(k); coe_data = 12'(v);
        @(posedge clk); #1;
        coe_we = 1'b0;
        if (k >= 1 && k <= 7) m_coef[k] = v;
    endtask

    task automatic pulse_clr();
        hist_clr = 1'b1;
        @(posedge clk); #1;
        hist_clr = 1'b0;
        model_clr();
    endtask

    // Called with din_ready high. Returns the output value, the number of
    // edges from accept to the strobe, and the number of cycles in which
    // din_ready was sampled low. When mac_wr is set, a coefficient write is
    // driven during the first MAC cycle.
    task automatic run_sample(input int x, input bit mac_wr,
                              output int y, output int lat, output int low);
        din = 21'(x); din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        if (mac_wr) begin
            coe_we = 1'b1; coe_addr = 3'd1; coe_data = 12'($urandom);
        end
        lat = 0; low = 0;
        while (dout_valid !== 1'b1 && lat < 40) begin
            if (din_ready === 1'b0) low++;
            @(posedge clk); #1;
            coe_we = 1'b0;
            lat++;
        end
        y = int'($signed(dout));
    endtask

    function automatic int rnd_din();
        return int'($urandom_range(0, 2097151)) - 1048576;
    endfunction

    initial begin
        int y, lat, low, pulses, last, x;
        int exp_q[$];
        int imp_exp[8];
        bit acc_now;
        imp_exp = '{100, 50, 25, 12, 6, 3, 1, 0};

        rst = 1'b1; din = '0; din_valid = 1'b0; coe_we = 1'b0;
        coe_addr = '0; coe_data = '0; hist_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_dout", $signed(dout), 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("rst_ovf", ovf, 0);

        // With all coefficients zero the block passes x >>> 9 straight through.
        run_sample(51200, 0, y, lat, low);
        chk("pass_dout", y, 100);
        chk("pass_latency", lat, 8);
        chk("pass_ready_low", low, 8);
        chk("pass_ready_after", din_ready, 1);
        void'(model_step(51200));
        @(posedge clk); #1;
        chk("pass_strobe_1cyc", dout_valid, 0);
        chk("pass_dout_hold", $signed(dout), 100);

        // Impulse response with a_1 = -256 (a pole at 0.5).
        write_coe(1, -256);
        pulse_clr();
        for (int i = 0; i < 8; i++) begin
            x = (i == 0) ? 51200 : 0;
            run_sample(x, 0, y, lat, low);
            chk($sformatf("impulse_%0d", i), y, imp_exp[i]);
            void'(model_step(x));
        end

        // Floor rounding.
        write_coe(1, 0);
        run_sample(-513, 0, y, lat, low);
        chk("floor_neg", y, -2);
        void'(model_step(-513));
        run_sample(511, 0, y, lat, low);
        chk("floor_pos", y, 0);
        void'(model_step(511));

        // Overflow handling.
        write_coe(1, -511);
        pulse_clr();
        run_sample(1048575, 0, y, lat, low);
        chk("ovf_first", y, 2047);
        void'(model_step(1048575));
        run_sample(1048575, 0, y, lat, low);
`ifdef POLE_SAT_EN
        chk("ovf_second", y, 2047);
        chk("ovf_flag", ovf, 1);
`else
        chk("ovf_second", y, -5);
        chk("ovf_flag", ovf, 0);
`endif
        void'(model_step(1048575));

        // A write to address 0 has no effect.
        write_coe(0, 100);

        // hist_clr beats an accept in the same cycle.
        din = 21'(51200); din_valid = 1'b1; hist_clr = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0; hist_clr = 1'b0;
        model_clr();
        chk("clr_prio_ready", din_ready, 1);
        pulses = 0;
        repeat (10) begin @(negedge clk); if (dout_valid === 1'b1) pulses++; end
        chk("clr_prio_nostrobe", pulses, 0);

        // Random coefficients with din_valid held high continuously.
        for (int k = 1; k <= 7; k++) write_coe(k, int'($urandom_range(0, 400)) - 200);
        pulse_clr();
        din = 21'(rnd_din()); din_valid = 1'b1; last = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            acc_now = 1'b0;
            if (dout_valid === 1'b1) begin
                if (exp_q.size() > 0) chk("stream_dout", $signed(dout), exp_q.pop_front());
                else chk("stream_extra_strobe", 1, 0);
            end
            if (din_ready === 1'b1) begin
                if (last >= 0) chk("stream_interval", c - last, 9);
                last = c;
                exp_q.push_back(model_step(int'($signed(din))));
                acc_now = 1'b1;
            end
            @(posedge clk); #1;
            if (acc_now) din = 21'(rnd_din());
        end
        din_valid = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) chk("stream_dout", $signed(dout), exp_q.pop_front());
        end
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_ovf", ovf, m_ovf);

        // A coefficient write during MAC is ignored.
        for (int i = 0; i < 2; i++) begin
            x = rnd_din();
            run_sample(x, 1, y, lat, low);
            chk($sformatf("macwr_dout_%0d", i), y, model_step(x));
        end

        // hist_clr in mid-MAC aborts the sample and clears the history.
        din = 21'(rnd_din()); din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 hist_clr = 1'b1;
        @(posedge clk); #1;
        hist_clr = 1'b0;
        model_clr();
        pulses = 0;
        repeat (12) begin @(negedge clk); if (dout_valid === 1'b1) pulses++; end
        chk("abort_nostrobe", pulses, 0);
        chk("abort_ready", din_ready, 1);
        x = rnd_din();
        run_sample(x, 0, y, lat, low);
        chk("abort_next_dout", y, model_step(x));

        // Asynchronous reset during the third MAC cycle.
        din = 21'(rnd_din()); din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("arst_ready_now", din_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses = 0;
        repeat (12) begin @(negedge clk); if (dout_valid === 1'b1) pulses++; end
        chk("arst_nostrobe", pulses, 0);
        chk("arst_dout", $signed(dout), 0);
        chk("arst_ready", din_ready, 1);
        chk("arst_ovf", ovf, 0);
        x = rnd_din();
        run_sample(x, 0, y, lat, low);
        chk("arst_next_dout", y, model_step(x));
        chk("arst_next_latency", lat, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
